// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: deframer state encoding, frame constants,
// default timing values and the frame parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int DATA_BITS = 8;
    localparam logic [7:0] PS2_RELEASE = 8'hF0;
    localparam logic [7:0] PS2_EXTEND  = 8'hE0;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_FILTER_CYCLES  = 8;
    localparam int DEF_TIMEOUT_CYCLES = 20000;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: multi-flop synchroniser followed by a consecutive-sample
// glitch filter; FILTER_CYCLES=0 passes the synchronised level straight through.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_in,
    output logic level,
    output logic fall
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((FILTER_CYCLES > 0) ? FILTER_CYCLES - 1 : 0);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   fall_q, fall_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pin_in};
        cnt_d   = '0;
        level_d = level_q;
        if (FILTER_CYCLES == 0) begin
            level_d = synced;
        end else if (synced != level_q) begin
            // Any sample that agrees with the current level restarts the count.
            if (cnt_q == CNT_MAX) level_d = synced;
            else                  cnt_d   = cnt_q + 1'b1;
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_rx_frontend.sv
// PS/2 keyboard receive front end: cleans up the pins, deframes 11-bit frames
// and strobes out good scancodes or error indications; can inhibit the device.
module ps2_rx_frontend
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    input  logic       inhibit,
    output logic       ps2_clk_oe,
    output logic [0:7] scancode,
    output logic       trigger,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam int BC_W = $clog2(DATA_BITS);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);

    logic clk_level, clk_fall, data_level, data_fall_unused;

    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clk(clk), .reset(reset), .pin_in(ps2_clk_in), .level(clk_level), .fall(clk_fall)
    );

    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(0)) u_data_sync (
        .clk(clk), .reset(reset), .pin_in(ps2_data_in), .level(data_level), .fall(data_fall_unused)
    );

    ps2_state_e             state_q, state_d;
    logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]        timeout_q, timeout_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   scancode_q, scancode_d;
    logic                   parity_q, parity_d;
    logic                   armed_q, armed_d;
    logic                   trigger_q, trigger_d;
    logic                   parity_error_q, parity_error_d;
    logic                   frame_error_q, frame_error_d;
    logic                   sample;

    assign sample = clk_fall & armed_q;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        parity_d       = parity_q;
        scancode_d     = scancode_q;
        armed_d        = armed_q;
        trigger_d      = 1'b0;
        parity_error_d = 1'b0;
        frame_error_d  = 1'b0;
        timeout_d      = (state_q == IDLE || sample) ? '0 : timeout_q + 1'b1;
        if (inhibit) begin
            // Dropping a frame because we inhibited is deliberate, not an error.
            state_d   = IDLE;
            armed_d   = 1'b0;
            timeout_d = '0;
        end else begin
            // Re-arm only once the clock is seen high again, so our own release does not count.
            if (!armed_q && clk_level) armed_d = 1'b1;
            if (sample) begin
                case (state_q)
                    IDLE: begin
                        if (!data_level) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end
                    end
                    DATA: begin
                        shift_d   = {data_level, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) state_d = PARITY;
                    end
                    PARITY: begin
                        parity_d = data_level;
                        state_d  = STOP;
                    end
                    STOP: begin
                        state_d = IDLE;
                        if (!data_level) begin
                            frame_error_d = 1'b1;
                        end else if (odd_parity_ok(shift_q, parity_q)) begin
                            scancode_d = shift_q;
                            trigger_d  = 1'b1;
                        end else begin
                            parity_error_d = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end else if (state_q != IDLE && timeout_q == TO_LAST) begin
                frame_error_d = 1'b1;
                state_d       = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            timeout_q      <= '0;
            armed_q        <= 1'b1;
            scancode_q     <= '0;
            trigger_q      <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            timeout_q      <= timeout_d;
            armed_q        <= armed_d;
            scancode_q     <= scancode_d;
            trigger_q      <= trigger_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
        parity_q <= parity_d;
    end

    assign ps2_clk_oe   = inhibit;
    assign scancode     = scancode_q;
    assign trigger      = trigger_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Directed bench for ps2_rx_frontend: a behavioural keyboard drives frames on a
// wired-AND clock line and a monitor tallies strobes and captured scancodes.
module tb_ps2_rx_frontend;

    localparam int SYNC     = 2;
    localparam int FILT     = 8;
    localparam int TIMEOUT  = 400;
    localparam int HALF     = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       kb_clk, kb_data;
    logic       ps2_clk_in, ps2_data_in;
    logic       inhibit;
    logic       ps2_clk_oe;
    logic [0:7] scancode;
    logic       trigger, parity_error, frame_error, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_trig   = 0;
    int n_perr   = 0;
    int n_ferr   = 0;
    int n_excl   = 0;
    logic [7:0] codes[$];

    always #5 clk = ~clk;

    assign ps2_clk_in  = kb_clk & ~ps2_clk_oe;
    assign ps2_data_in = kb_data;

    ps2_rx_frontend #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .inhibit(inhibit), .ps2_clk_oe(ps2_clk_oe), .scancode(scancode), .trigger(trigger),
        .parity_error(parity_error), .frame_error(frame_error), .busy(busy)
    );

    always @(negedge clk) begin
        if (!reset) begin
            if (trigger) begin
                n_trig++;
                codes.push_back(scancode);
            end
            if (parity_error) n_perr++;
            if (frame_error)  n_ferr++;
            if (int'(trigger) + int'(parity_error) + int'(frame_error) > 1) n_excl++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        kb_data = b;
        repeat (HALF) @(posedge clk);
        kb_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        kb_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] val, input logic par_flip, input logic stop_v,
                              input logic check_busy);
        logic par;
        par = ~^val ^ par_flip;
        send_bit(1'b0);
        if (check_busy) begin
            @(negedge clk);
            check("busy_after_start", busy, 1);
        end
        for (int i = 0; i < 8; i++) send_bit(val[i]);
        send_bit(par);
        send_bit(stop_v);
        kb_data = 1'b1;
        if (check_busy) begin
            @(negedge clk);
            check("busy_after_stop", busy, 0);
        end
    endtask

    initial begin
        int t0, p0, f0, q0;
        reset   = 1'b1;
        inhibit = 1'b1;
        kb_clk  = 1'b1;
        kb_data = 1'b1;
        idle(4);
        check("reset_oe_follows_inhibit", ps2_clk_oe, 1);
        inhibit = 1'b0;
        idle(2);
        check("reset_oe", ps2_clk_oe, 0);
        check("reset_scancode", scancode, 8'h00);
        check("reset_trigger", trigger, 0);
        check("reset_parity_error", parity_error, 0);
        check("reset_frame_error", frame_error, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        idle(20);

        // single good frame
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
        idle(HALF);
        check("good_trig_count", n_trig, 1);
        check("good_code", codes[0], 8'h1C);
        check("good_scancode_port", scancode, 8'h1C);
        check("good_perr", n_perr, 0);
        check("good_ferr", n_ferr, 0);

        // release sequence, back to back
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        idle(HALF);
        check("release_trig_count", n_trig, 3);
        check("release_code0", codes[1], 8'hF0);
        check("release_code1", codes[2], 8'h1C);

        // bad stop bit
        t0 = n_trig; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        idle(HALF);
        check("stop_err_ferr", n_ferr - f0, 1);
        check("stop_err_trig", n_trig - t0, 0);
        check("stop_err_perr", n_perr - p0, 0);

        // timeout on a partial frame
        t0 = n_trig; f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk);
        check("timeout_busy_mid", busy, 1);
        idle(TIMEOUT + 10);
        check("timeout_ferr", n_ferr - f0, 1);
        check("timeout_busy", busy, 0);
        check("timeout_trig", n_trig - t0, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        idle(HALF);
        check("after_timeout_trig", n_trig - t0, 1);
        check("after_timeout_code", scancode, 8'h5A);

        // parity error keeps the previous scancode
        t0 = n_trig; p0 = n_perr; f0 = n_ferr;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        idle(HALF);
        check("parity_perr", n_perr - p0, 1);
        check("parity_trig", n_trig - t0, 0);
        check("parity_ferr", n_ferr - f0, 0);
        check("parity_scancode_held", scancode, 8'h5A);
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        idle(HALF);
        check("after_parity_trig", n_trig - t0, 1);
        check("after_parity_code", scancode, 8'h29);

        // short clock glitch with data low must not start a frame
        t0 = n_trig; p0 = n_perr; f0 = n_ferr;
        kb_data = 1'b0;
        @(posedge clk);
        kb_clk = 1'b0;
        repeat (3) @(posedge clk);
        kb_clk = 1'b1;
        idle(40);
        check("glitch_busy", busy, 0);
        kb_data = 1'b1;
        idle(40);

        // inhibit mid-frame
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        @(negedge clk);
        check("inhibit_pre_busy", busy, 1);
        inhibit = 1'b1;
        kb_data = 1'b1;
        idle(20);
        check("inhibit_oe", ps2_clk_oe, 1);
        check("inhibit_busy", busy, 0);
        idle(100);
        inhibit = 1'b0;
        idle(60);
        check("inhibit_oe_released", ps2_clk_oe, 0);
        check("inhibit_busy_after", busy, 0);
        q0 = n_trig - t0 + n_perr - p0 + n_ferr - f0;
        check("inhibit_no_strobes", q0, 0);
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        idle(HALF);
        check("after_inhibit_trig", n_trig - t0, 1);
        check("after_inhibit_code", scancode, 8'hE0);
        check("scancode_bit0_is_msb", scancode[0], 1);
        check("scancode_bit7_is_lsb", scancode[7], 0);
        check("strobes_exclusive", n_excl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
